// File: rtl/io_port_bridge.sv
// rtl/io_port_bridge.sv - input and output word FIFOs between the processor ports and external devices
// Both FIFOs share one clock; flags come from registered counts only.
module io_port_bridge #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic             in_rd,
  output logic [WIDTH-1:0] portIn,
  output logic             in_empty,
  input  logic             out_wr,
  input  logic [WIDTH-1:0] portOut,
  output logic [WIDTH-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [CW-1:0]    in_count,
  output logic [CW-1:0]    out_count,
  output logic             err_underflow,
  output logic             err_overflow
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [WIDTH-1:0] inMem [DEPTH];
  logic [PW-1:0]    inWrPtr, inRdPtr;
  logic [CW-1:0]    inCnt;
  logic             inPush, inPop;

  logic [WIDTH-1:0] outMem [DEPTH];
  logic [PW-1:0]    outWrPtr, outRdPtr;
  logic [CW-1:0]    outCnt;
  logic             outPush, outDrain;

  assign s_ready   = (inCnt != FULL);
  assign in_empty  = (inCnt == '0);
  assign in_count  = inCnt;
  assign inPush    = s_valid && s_ready;
  assign inPop     = in_rd && !in_empty;

  assign m_valid   = (outCnt != '0);
  assign m_data    = outMem[outRdPtr];
  assign out_count = outCnt;
  assign outDrain  = m_valid && m_ready;
  // A full FIFO still accepts a write when its head leaves in the same cycle.
  assign outPush   = out_wr && ((outCnt != FULL) || outDrain);

  always_ff @(posedge clk) begin
    if (reset) begin
      inWrPtr       <= '0;
      inRdPtr       <= '0;
      inCnt         <= '0;
      portIn        <= '0;
      err_underflow <= 1'b0;
    end else begin
      if (inPush)
        inWrPtr <= inWrPtr + 1'b1;
      if (inPop) begin
        portIn  <= inMem[inRdPtr];
        inRdPtr <= inRdPtr + 1'b1;
      end
      if (in_rd && in_empty)
        err_underflow <= 1'b1;
      if (inPush && !inPop)
        inCnt <= inCnt + 1'b1;
      else if (!inPush && inPop)
        inCnt <= inCnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      outWrPtr     <= '0;
      outRdPtr     <= '0;
      outCnt       <= '0;
      err_overflow <= 1'b0;
    end else begin
      if (outPush)
        outWrPtr <= outWrPtr + 1'b1;
      if (outDrain)
        outRdPtr <= outRdPtr + 1'b1;
      if (out_wr && !outPush)
        err_overflow <= 1'b1;
      if (outPush && !outDrain)
        outCnt <= outCnt + 1'b1;
      else if (!outPush && outDrain)
        outCnt <= outCnt - 1'b1;
    end
  end

  // Storage is never cleared; only pointers and counts reset.
  always_ff @(posedge clk) begin
    if (!reset && inPush)
      inMem[inWrPtr] <= s_data;
    if (!reset && outPush)
      outMem[outWrPtr] <= portOut;
  end
endmodule
